// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR (x^4+x+1) generator and its checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W      = 4;
  localparam int unsigned LFSR_PERIOD = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    ZERO   = 2'd3
  } chk_state_t;

  // Next value of the LFSR counter stage.
  function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] q);
    return {q[0] ^ q[1], q[3], q[2], q[1]};
  endfunction

endpackage

// File: rtl/lfsr4_predict.sv
// Combinational predictor: next LFSR value from the current one.
module lfsr4_predict
  import lfsr_pkg::*;
(
  input  logic [3:0] cur,
  output logic [3:0] nxt
);

  // Single definition of the sequence, shared with the generator.
  always_comb begin
    nxt = lfsr4_next(cur);
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Monitors a 4-bit LFSR stream: locks after SYNC_LEN correct predictions,
// flags mismatches, stuck-at-zero input and sequence wrap.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_det,
  output logic [3:0]       seq_idx,
  output logic             wrap
);

  localparam logic [3:0] SYNC_TGT = SYNC_LEN[3:0];
  localparam logic [3:0] SEQ_LAST = 4'(LFSR_PERIOD - 1);

  chk_state_t state;
  logic [3:0] prev;
  logic [3:0] pred;
  logic [3:0] match_cnt;

  lfsr4_predict u_pred (
    .cur (prev),
    .nxt (pred)
  );

  // Checker FSM with its counters; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      zero_det  <= 1'b0;
      seq_idx   <= '0;
      wrap      <= 1'b0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (din == '0) begin
              state    <= ZERO;
              zero_det <= 1'b1;
            end else begin
              prev      <= din;
              match_cnt <= '0;
              state     <= SYNC;
            end
          end

          SYNC: begin
            prev <= din;
            if (din == '0) begin
              state     <= ZERO;
              zero_det  <= 1'b1;
              match_cnt <= '0;
            end else if (din == pred) begin
              if (match_cnt + 4'd1 == SYNC_TGT) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                seq_idx   <= '0;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            prev <= din;
            if (din == pred) begin
              if (seq_idx == SEQ_LAST) begin
                seq_idx <= '0;
                wrap    <= 1'b1;
              end else begin
                seq_idx <= seq_idx + 4'd1;
              end
            end else begin
              // A zero sample here is still a mismatch, so it is counted
              // even though the FSM lands in ZERO rather than SYNC.
              err       <= 1'b1;
              if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
              locked    <= 1'b0;
              seq_idx   <= '0;
              match_cnt <= '0;
              if (din == '0) begin
                state    <= ZERO;
                zero_det <= 1'b1;
              end else begin
                state <= SYNC;
              end
            end
          end

          ZERO: begin
            if (din != '0) begin
              prev      <= din;
              match_cnt <= '0;
              zero_det  <= 1'b0;
              state     <= SYNC;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed, table-driven bench for lfsr_stream_checker.
module tb_lfsr_stream_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] din;
  logic       locked, err, zero_det, wrap;
  logic [7:0] err_count;
  logic [3:0] seq_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_stream_checker #(.SYNC_LEN(3), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .din       (din),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .zero_det  (zero_det),
    .seq_idx   (seq_idx),
    .wrap      (wrap)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] din;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic       zd;
    logic [3:0] si;
    logic       wr;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] tb_next(input logic [3:0] x);
    return {x[0] ^ x[1], x[3], x[2], x[1]};
  endfunction

  task automatic add(input logic r, input logic e, input logic [3:0] d,
                     input logic lk, input logic er, input logic [7:0] ec,
                     input logic zd, input logic [3:0] si, input logic wr,
                     input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.lk = lk; v.er = er; v.ec = ec;
    v.zd = zd; v.si = si; v.wr = wr; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] d);
    reset = r; en = e; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic lk, input logic er,
                     input logic [7:0] ec, input logic zd, input logic [3:0] si,
                     input logic wr);
    n_checks++;
    if ({locked, err, err_count, zero_det, seq_idx, wrap} !==
        {lk, er, ec, zd, si, wr}) begin
      n_fail++;
      $display("FAIL %s: got locked=%b err=%b err_count=%0d zero_det=%b seq_idx=%0d wrap=%b, expected locked=%b err=%b err_count=%0d zero_det=%b seq_idx=%0d wrap=%b",
               nm, locked, err, err_count, zero_det, seq_idx, wrap,
               lk, er, ec, zd, si, wr);
    end
  endtask

  initial begin
    logic [3:0] cur, pred, bad;
    int exp_ec;
    logic [3:0] per [14];

    // Reset and stuck-zero from IDLE, then lock from 0001.
    add(1,0,4'b0000, 0,0,0,0,0,0, "reset");
    add(0,1,4'b0000, 0,0,0,1,0,0, "zero_idle");
    add(0,1,4'b0000, 0,0,0,1,0,0, "zero_hold");
    add(0,1,4'b0001, 0,0,0,0,0,0, "zero_exit");
    add(0,1,4'b1000, 0,0,0,0,0,0, "sync1");
    add(0,1,4'b0100, 0,0,0,0,0,0, "sync2");
    add(0,1,4'b0010, 1,0,0,0,0,0, "lock");
    // Full period: seq_idx 1..14 then wrap to 0.
    per = '{4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
            4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100};
    for (int i = 0; i < 14; i++)
      add(0,1,per[i], 1,0,0,0,4'(i+1),0, "period");
    add(0,1,4'b0010, 1,0,0,0,0,1, "wrap");
    // Mismatch and relock.
    add(0,1,4'b1001, 1,0,0,0,1,0, "post_wrap");
    add(0,1,4'b1111, 0,1,1,0,0,0, "mismatch");
    add(0,1,4'b0111, 0,0,1,0,0,0, "resync1");
    add(0,1,4'b0011, 0,0,1,0,0,0, "resync2");
    add(0,1,4'b0001, 1,0,1,0,0,0, "relock");
    add(0,1,4'b1000, 1,0,1,0,1,0, "idx1");
    // en=0 gating: everything frozen, prev held.
    add(0,0,4'b0000, 1,0,1,0,1,0, "gate");
    add(0,0,4'b0100, 1,0,1,0,1,0, "gate");
    add(0,0,4'b1111, 1,0,1,0,1,0, "gate");
    add(0,0,4'b0000, 1,0,1,0,1,0, "gate");
    add(0,0,4'b0011, 1,0,1,0,1,0, "gate");
    add(0,1,4'b0100, 1,0,1,0,2,0, "ungate");
    // Zero while locked: err pulse and ZERO on the same edge.
    add(0,1,4'b0000, 0,1,2,1,0,0, "lock_zero");
    add(0,1,4'b0000, 0,0,2,1,0,0, "zero_hold2");
    add(0,1,4'b0001, 0,0,2,0,0,0, "zero_exit2");
    add(0,1,4'b1000, 0,0,2,0,0,0, "sync1b");
    add(0,1,4'b0100, 0,0,2,0,0,0, "sync2b");
    add(0,1,4'b0010, 1,0,2,0,0,0, "lock_b");
    add(0,1,4'b1001, 1,0,2,0,1,0, "idx1b");
    // Reset wins over en mid-lock and clears err_count.
    add(1,1,4'b1100, 0,0,0,0,0,0, "reset_midlock");
    add(0,1,4'b0001, 0,0,0,0,0,0, "seed_after_rst");

    reset = 1'b1; en = 1'b0; din = '0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].din);
      chk(tbl[i].name, tbl[i].lk, tbl[i].er, tbl[i].ec, tbl[i].zd,
          tbl[i].si, tbl[i].wr);
    end

    // Saturation: 300 lock/mismatch rounds starting from SYNC, prev=0001.
    cur = 4'b0001;
    exp_ec = 0;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        cur = tb_next(cur);
        step(0, 1, cur);
      end
      chk("sat_lock", 1, 0, 8'(exp_ec), 0, 0, 0);
      pred = tb_next(cur);
      bad  = (pred == 4'b0001) ? 4'b0010 : 4'b0001;
      step(0, 1, bad);
      exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
      chk("sat_err", 0, 1, 8'(exp_ec), 0, 0, 0);
      cur = bad;
    end
    step(0, 0, 4'b0000);
    chk("sat_hold", 0, 0, 8'd255, 0, 0, 0);
    step(1, 0, 4'b0000);
    chk("final_reset", 0, 0, 8'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Downstream consumer of the 4-bit LFSR counter stage (polynomial x^4+x+1, next = {q[0]^q[1], q[3], q[2], q[1]}). It samples the generator output, predicts each next value, and reports lock, mismatches, all-zero lock-up, and sequence wrap. It is the self-check and bring-up monitor placed after the generator, and its outputs feed status and error logging.

## Interface
- SYNC_LEN, 3: consecutive correct predictions required to declare lock (1..15).
- ERR_W, 8: width of the saturating error counter.

- clk  in  1  rising-edge clock, shared with the LFSR stage.
- reset  in  1  synchronous, active-high; one clock, synchronous reset; all state is cleared on the edge where it is high.
- en  in  1  sample strobe; din is sampled only on edges where en=1.
- din  in  4  LFSR output value.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a prediction mismatch while LOCKED.
- err_count  out  ERR_W  number of mismatches, saturating at all-ones.
- zero_det  out  1  high while in ZERO (stuck all-zero input).
- seq_idx  out  4  position 0..14 since lock; 0 when not locked.
- wrap  out  1  one-cycle pulse when seq_idx wraps from 14 to 0.

## Operation
- Registers: state, prev[3:0] (last accepted sample), match_cnt, seq_idx, err_count. pred = next(prev).
- Reset values: state=IDLE, prev=0, match_cnt=0, and all outputs are 0.
- en=0: all state holds, and err and wrap are 0.
- IDLE, en=1: din==0 → ZERO; otherwise prev<=din, match_cnt<=0 → SYNC.
- SYNC, en=1:
  - din==0 → ZERO.
  - din==pred: match_cnt+1. If this reaches SYNC_LEN → LOCKED with seq_idx<=0.
  - Otherwise match_cnt<=0 and the state stays SYNC (re-seed).
  - prev<=din in all cases.
- LOCKED, en=1:
  - din==pred: seq_idx<=(seq_idx==14)?0:seq_idx+1. wrap=1 when the index wraps.
  - din!=pred: err=1, err_count+1 (saturating), → SYNC with match_cnt<=0 and seq_idx<=0. If din==0, go to ZERO instead (err is still pulsed).
  - prev<=din in all cases.
- ZERO, en=1: din!=0 → SYNC with prev<=din and match_cnt<=0; otherwise hold. Entering ZERO from IDLE or SYNC does not count as an error.
- err_count is cleared only by reset. It is never cleared by a re-sync.

## Timing
- Every output is registered. The effect of a sample taken at edge k is visible right after edge k (latency 1 edge from sample to output).
- From the first nonzero sample, the earliest lock is SYNC_LEN further accepted samples. With SYNC_LEN=3, locked rises at the 4th en edge.
- err and wrap are high for exactly one cycle. They never assert in the same cycle.
- reset has priority over en in any state, including mid-lock. On the next edge every output returns to its reset value, including err_count.
- Simultaneous mismatch and zero input while LOCKED: the err pulse and the move to ZERO happen on the same edge.

## Structure
- Package lfsr_pkg holds:
  - the next-state function lfsr4_next (shared with the generator);
  - the state enumeration IDLE/SYNC/LOCKED/ZERO;
  - LFSR_PERIOD=15 and LFSR_W=4.
- Sub-module lfsr4_predict: a combinational predictor wrapping lfsr4_next, so the checker and any future generator variant use one definition.
- The checker itself is a single FSM with its counters.

## Test plan
- Clean lock: reset, then en=1 with din = 0001, 1000, 0100, 0010 → locked=1 after the 4th edge, seq_idx=0, err=0.
- Full period: continue with 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, 1000, 0100, 0010 → seq_idx counts 1..14,0, and wrap pulses once, on the edge sampling the second 0010.
- Mismatch: while locked, after 1001 drive 1111 instead of 1100 → err pulses one cycle, err_count=1, locked=0. Then 0111, 0011, 0001 → relock (locked=1) after 0001.
- Zero lock-up: drive din=0000 in IDLE → zero_det=1 and stays high through repeated zeros. Then din=0001 → zero_det=0 and state SYNC, with err_count unchanged.
- Gating and saturation:
  - en=0 for 5 cycles mid-lock → outputs frozen and no pulses.
  - Force 300 mismatches with ERR_W=8 → err_count holds at 255.
  - Assert reset mid-lock → all outputs are 0 after one edge.
